// File: rtl/fetch_seq_ctrl.sv
// rtl/fetch_seq_ctrl.sv - instruction fetch sequencer with redirect arbitration; FETCH_ADEF_EN adds misaligned-PC adef reporting
module fetch_seq_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1C000000,
  parameter logic [31:0] PC_STEP  = 32'd4,
`ifdef FETCH_ADEF_EN
  localparam int BUS_W = 65
`else
  localparam int BUS_W = 64
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             excp_flush,
  input  logic [31:0]      eentry,
  input  logic             ertn_flush,
  input  logic [31:0]      era,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [31:0]      inst_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_pc, w_pc_nxt;
  logic             r_cancel, w_cancel_nxt;
  logic [BUS_W-1:0] r_bus, w_bus_nxt;
  logic             r_run;
  logic             w_redir;
  logic [31:0]      w_tgt;
  logic             w_adef;
  logic             w_hold_adef;
  logic             w_req;

  assign w_redir = excp_flush | ertn_flush | br_taken;
  assign w_tgt   = excp_flush ? eentry : (ertn_flush ? era : br_target);

`ifdef FETCH_ADEF_EN
  assign w_adef      = (r_pc[1:0] != 2'b00);
  assign w_hold_adef = r_bus[BUS_W-1];
`else
  assign w_adef      = 1'b0;
  assign w_hold_adef = 1'b0;
`endif

  // r_run delays the first request by one cycle after reset release
  assign w_req     = r_run & (r_state == S_REQ) & ~w_adef;
  assign inst_req  = w_req;
  assign inst_addr = r_pc;
  assign out_valid = (r_state == S_HOLD);
  assign out_bus   = r_bus;

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_cancel_nxt = r_cancel;
    w_bus_nxt    = r_bus;
    case (r_state)
      S_REQ: begin
        if (w_req && inst_addr_ok) begin
          w_state_nxt = S_WAIT;
          if (w_redir) begin
            w_pc_nxt     = w_tgt;
            w_cancel_nxt = 1'b1;
          end
        end else if (w_redir) begin
          w_pc_nxt = w_tgt;
        end else if (w_adef && r_run) begin
          w_state_nxt = S_HOLD;
`ifdef FETCH_ADEF_EN
          w_bus_nxt   = {1'b1, r_pc, 32'h0};
`endif
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          if (r_cancel || w_redir) begin
            // stale or just-redirected response: drop it and refetch
            w_state_nxt  = S_REQ;
            w_cancel_nxt = 1'b0;
            if (w_redir) w_pc_nxt = w_tgt;
          end else begin
            w_state_nxt = S_HOLD;
            w_bus_nxt   = BUS_W'({r_pc, inst_rdata});
          end
        end else if (w_redir) begin
          w_pc_nxt     = w_tgt;
          w_cancel_nxt = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_redir) begin
          w_state_nxt = S_REQ;
          w_pc_nxt    = w_tgt;
        end else if (out_ready) begin
          w_state_nxt = S_REQ;
          if (!w_hold_adef) w_pc_nxt = r_pc + PC_STEP;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_cancel <= 1'b0;
      r_bus    <= '0;
      r_run    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_cancel <= w_cancel_nxt;
      r_bus    <= w_bus_nxt;
      r_run    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// tb/tb_fetch_seq_ctrl.sv - directed self-checking bench for fetch_seq_ctrl
module tb_fetch_seq_ctrl;
`ifdef FETCH_ADEF_EN
  localparam int BW = 65;
`else
  localparam int BW = 64;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          excp_flush = 1'b0;
  logic [31:0]   eentry = '0;
  logic          ertn_flush = 1'b0;
  logic [31:0]   era = '0;
  logic          br_taken = 1'b0;
  logic [31:0]   br_target = '0;
  logic          inst_req;
  logic [31:0]   inst_addr;
  logic          inst_addr_ok = 1'b0;
  logic          inst_data_ok = 1'b0;
  logic [31:0]   inst_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_bus;
  logic [64:0]   bus65;

  int n_checks = 0;
  int n_errors = 0;

  assign bus65 = 65'(out_bus);

  always #5 clk = ~clk;

  fetch_seq_ctrl dut (
    .clk(clk), .reset(reset),
    .excp_flush(excp_flush), .eentry(eentry),
    .ertn_flush(ertn_flush), .era(era),
    .br_taken(br_taken), .br_target(br_target),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_bus(out_bus)
  );

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [64:0] exp_bus(input logic [31:0] pc, input logic [31:0] ins, input logic adef);
    return {adef, pc, ins};
  endfunction

  task automatic wait_req();
    for (int i = 0; i < 20 && !inst_req; i++) @(negedge clk);
    check("req_seen", 65'(inst_req), 65'd1);
  endtask

  // issue one request, return data next cycle; ends in HOLD at a negedge
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
    wait_req();
    check("addr", 65'(inst_addr), 65'(addr));
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    check("req_in_wait", 65'(inst_req), 65'd0);
    inst_data_ok = 1'b1;
    inst_rdata   = data;
    @(negedge clk);
    inst_data_ok = 1'b0;
    check("valid", 65'(out_valid), 65'd1);
    check("bus", bus65, exp_bus(addr, data, 1'b0));
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", 65'(out_valid), 65'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_req", 65'(inst_req), 65'd0);
    check("rst_valid", 65'(out_valid), 65'd0);
    check("rst_bus", bus65, 65'd0);
    reset = 1'b1;
    @(negedge clk);
    check("first_req", 65'(inst_req), 65'd1);
    check("first_addr", 65'(inst_addr), 65'h1C000000);

    fetch(32'h1C000000, 32'h02800C0C); accept();
    fetch(32'h1C000004, 32'h1C00000D); accept();
    fetch(32'h1C000008, 32'h4C000020); accept();

    fetch(32'h1C00000C, 32'hA5A55A5A);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 65'(out_valid), 65'd1);
      check("hold_bus", bus65, exp_bus(32'h1C00000C, 32'hA5A55A5A, 1'b0));
      check("hold_noreq", 65'(inst_req), 65'd0);
    end
    accept();

    wait_req();
    check("t3_addr", 65'(inst_addr), 65'h1C000010);
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    br_taken  = 1'b1;
    br_target = 32'h1C000100;
    @(negedge clk);
    br_taken = 1'b0;
    check("t3_noreq", 65'(inst_req), 65'd0);
    @(negedge clk);
    check("t3_novalid", 65'(out_valid), 65'd0);
    @(negedge clk);
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hDEADBEEF;
    @(negedge clk);
    inst_data_ok = 1'b0;
    check("t3_dropped", 65'(out_valid), 65'd0);
    check("t3_req", 65'(inst_req), 65'd1);
    check("t3_new_addr", 65'(inst_addr), 65'h1C000100);
    fetch(32'h1C000100, 32'h00000001); accept();

    fetch(32'h1C000104, 32'h00000002);
    excp_flush = 1'b1; eentry = 32'h1C008000;
    br_taken   = 1'b1; br_target = 32'h1C000200;
    out_ready  = 1'b1;
    @(negedge clk);
    excp_flush = 1'b0; br_taken = 1'b0; out_ready = 1'b0;
    check("t4_valid", 65'(out_valid), 65'd0);
    check("t4_req", 65'(inst_req), 65'd1);
    check("t4_addr", 65'(inst_addr), 65'h1C008000);
    fetch(32'h1C008000, 32'h00000003); accept();

    wait_req();
    check("t5_addr", 65'(inst_addr), 65'h1C008004);
    inst_addr_ok = 1'b1;
    @(negedge clk);
    inst_addr_ok = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("t5_req", 65'(inst_req), 65'd0);
    check("t5_valid", 65'(out_valid), 65'd0);
    check("t5_bus", bus65, 65'd0);
    @(negedge clk);
    reset        = 1'b1;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hBAD0BAD0;
    @(negedge clk);
    inst_data_ok = 1'b0;
    check("t5_late_valid", 65'(out_valid), 65'd0);
    check("t5_restart_req", 65'(inst_req), 65'd1);
    check("t5_restart_addr", 65'(inst_addr), 65'h1C000000);
    fetch(32'h1C000000, 32'h00000004); accept();

    wait_req();
    ertn_flush = 1'b1; era = 32'hFFFFFFFC;
    br_taken   = 1'b1; br_target = 32'h1C000300;
    @(negedge clk);
    ertn_flush = 1'b0; br_taken = 1'b0;
    check("prio_addr", 65'(inst_addr), 65'hFFFFFFFC);
    fetch(32'hFFFFFFFC, 32'h00000005); accept();
    wait_req();
    check("wrap_addr", 65'(inst_addr), 65'h0);

`ifdef FETCH_ADEF_EN
    br_taken  = 1'b1;
    br_target = 32'h1C000102;
    @(negedge clk);
    br_taken = 1'b0;
    check("adef_noreq", 65'(inst_req), 65'd0);
    @(negedge clk);
    check("adef_valid", 65'(out_valid), 65'd1);
    check("adef_bus", bus65, exp_bus(32'h1C000102, 32'h0, 1'b1));
    check("adef_noreq2", 65'(inst_req), 65'd0);
    ertn_flush = 1'b1; era = 32'h1C000010;
    @(negedge clk);
    ertn_flush = 1'b0;
    check("adef_clr", 65'(out_valid), 65'd0);
    check("adef_rec_addr", 65'(inst_addr), 65'h1C000010);
    fetch(32'h1C000010, 32'h00000006); accept();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
